div_clk_ctrl: RTL and testbench

Run-time controller for the integer clock divider. It owns the active divide ratio and accepts new ratios through a valid/ready config port. Ratio changes and start/stop requests take effect only on a divided-period boundary, so div_clk never has a runt pulse. It drives the divider counter and waveform and reports period ticks to downstream sequencing logic.

---
 rtl/div_pkg.sv | 7 +
 rtl/div_clk_gen.sv | 59 +++++
 rtl/div_clk_ctrl.sv | 84 ++++++++
 tb/tb_div_clk_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared width default, minimum legal ratio and controller state encoding
// for the run-time clock divider.
package div_pkg;
    localparam int CNT_W_DEF = 8;
    localparam int DIV_MIN = 2;
    typedef enum logic [1:0] {S_OFF, S_RUN, S_PEND, S_STOP} state_t;
endpackage

// File: rtl/div_clk_gen.sv
// div_clk_gen: period counter, waveform flops and period tick of the integer divider.
// Optional DIV_CLK_ODD_DUTY50_EN adds a negedge copy of pos_q for 50% duty on odd ratios.
module div_clk_gen
    import div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DIV_DEFAULT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             load,
    input  logic [CNT_W-1:0] div_n,
    output logic             at_end,
    output logic             period_tick,
    output logic             div_clk
);
    logic [CNT_W-1:0] cnt, cnt_next, per_q, per_next;
    logic [CNT_W:0]   half;
    logic             run_q, pos_q;

    // per_q is the ratio of the period being counted; it only changes on a load so
    // a ratio change never shortens or stretches the running period.
    always_comb begin
        per_next = load ? div_n : per_q;
        cnt_next = (!run || load) ? '0 : cnt + 1'b1;
        half     = ({1'b0, per_next} + 1'b1) >> 1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            per_q <= CNT_W'(DIV_DEFAULT);
            run_q <= 1'b0;
            pos_q <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            per_q <= per_next;
            run_q <= run;
            pos_q <= run && ({1'b0, cnt_next} < half);
        end
    end

    assign at_end      = run_q && (cnt == per_q - 1'b1);
    assign period_tick = run_q && (cnt == '0);

`ifdef DIV_CLK_ODD_DUTY50_EN
    logic neg_q;

    always_ff @(negedge clk) begin
        if (!rst_n) neg_q <= 1'b0;
        else neg_q <= pos_q;
    end

    assign div_clk = per_q[0] ? (pos_q & neg_q) : pos_q;
`else
    assign div_clk = pos_q;
`endif
endmodule

// File: rtl/div_clk_ctrl.sv
// div_clk_ctrl: run-time divider controller; ratio handshake, pending ratio and
// boundary-aligned start/stop. Optional DIV_CLK_ODD_DUTY50_EN lives in div_clk_gen.
module div_clk_ctrl
    import div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DIV_DEFAULT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic [CNT_W-1:0] cur_div,
    output logic             div_busy,
    output logic             period_tick,
    output logic             div_clk
);
    state_t           state, state_n;
    logic [CNT_W-1:0] cur_n, pend_div, pend_n;
    logic             pend_v, pv_n, load, at_end, accept, acc_ok;

    assign cfg_ready = state != S_PEND;
    assign accept    = cfg_valid && cfg_ready;
    assign acc_ok    = accept && (cfg_div >= CNT_W'(DIV_MIN));
    assign div_busy  = state != S_OFF;

    always_comb begin
        state_n = state;
        cur_n   = cur_div;
        pend_n  = pend_div;
        pv_n    = pend_v;
        load    = 1'b1;
        if (state == S_OFF) begin
            if (acc_ok) cur_n = cfg_div;
            if (div_en) state_n = S_RUN;
        end else begin
            load = at_end;
            // In STOP the new ratio is reported at once but only counted from the next period.
            if (acc_ok && (state == S_STOP || at_end)) begin
                cur_n = cfg_div;
                pv_n  = 1'b0;
            end else if (acc_ok) begin
                pend_n = cfg_div;
                pv_n   = 1'b1;
            end
            if (at_end && pv_n) begin
                cur_n = pend_n;
                pv_n  = 1'b0;
            end
            state_n = at_end ? (div_en ? S_RUN : S_OFF)
                             : (div_en ? (pv_n ? S_PEND : S_RUN) : S_STOP);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_OFF;
            cur_div  <= CNT_W'(DIV_DEFAULT);
            pend_div <= '0;
            pend_v   <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            state    <= state_n;
            cur_div  <= cur_n;
            pend_div <= pend_n;
            pend_v   <= pv_n;
            cfg_err  <= accept && !acc_ok;
        end
    end

    div_clk_gen #(.CNT_W(CNT_W), .DIV_DEFAULT(DIV_DEFAULT)) u_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (state_n != S_OFF),
        .load       (load),
        .div_n      (cur_n),
        .at_end     (at_end),
        .period_tick(period_tick),
        .div_clk    (div_clk)
    );
endmodule

// File: tb/tb_div_clk_ctrl.sv
// tb_div_clk_ctrl: vector table with scoreboard queue plus hand sequences for the
// divider controller (default build, odd-duty feature off).
module tb_div_clk_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0, div_en = 1'b0, cfg_valid = 1'b0;
    logic [7:0] cfg_div = 8'd0;
    logic       cfg_ready, cfg_err, div_busy, period_tick, div_clk;
    logic [7:0] cur_div;

    always #5 clk = ~clk;

    div_clk_ctrl #(.CNT_W(8), .DIV_DEFAULT(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .div_en     (div_en),
        .cfg_valid  (cfg_valid),
        .cfg_div    (cfg_div),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .cur_div    (cur_div),
        .div_busy   (div_busy),
        .period_tick(period_tick),
        .div_clk    (div_clk)
    );

    typedef struct {
        logic       rst_n, en, v;
        logic [7:0] d;
        logic       ready, err;
        logic [7:0] cur;
        logic       busy, tick, dclk;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   total = 0, bad = 0;

    function automatic vec_t mk(logic r, logic e, logic v, logic [7:0] d, logic rdy,
                                logic er, logic [7:0] c, logic b, logic t, logic k);
        vec_t x;
        x.rst_n = r; x.en = e; x.v = v; x.d = d;
        x.ready = rdy; x.err = er; x.cur = c; x.busy = b; x.tick = t; x.dclk = k;
        return x;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t e;
        int ticks, highs;
        // rst en v d | ready err cur busy tick clk   (outputs after the edge)
        vecs.push_back(mk(0,0,0,0, 1,0,3,0,0,0));
        vecs.push_back(mk(0,1,0,0, 1,0,3,0,0,0));
        vecs.push_back(mk(1,1,0,0, 1,0,3,1,1,1));   // start N=3
        vecs.push_back(mk(1,1,0,0, 1,0,3,1,0,1));
        vecs.push_back(mk(1,1,0,0, 1,0,3,1,0,0));
        vecs.push_back(mk(1,1,0,0, 1,0,3,1,1,1));
        vecs.push_back(mk(1,1,1,4, 0,0,3,1,0,1));   // 4 offered at cnt0 -> PEND
        vecs.push_back(mk(1,1,0,0, 0,0,3,1,0,0));
        vecs.push_back(mk(1,1,0,0, 1,0,4,1,1,1));   // N=4 HHLL
        vecs.push_back(mk(1,1,0,0, 1,0,4,1,0,1));
        vecs.push_back(mk(1,1,0,0, 1,0,4,1,0,0));
        vecs.push_back(mk(1,1,0,0, 1,0,4,1,0,0));
        vecs.push_back(mk(1,1,0,0, 1,0,4,1,1,1));
        vecs.push_back(mk(1,1,1,1, 1,1,4,1,0,1));   // illegal ratio
        vecs.push_back(mk(1,1,0,0, 1,0,4,1,0,0));
        vecs.push_back(mk(1,1,0,0, 1,0,4,1,0,0));
        vecs.push_back(mk(1,1,0,0, 1,0,4,1,1,1));
        vecs.push_back(mk(1,1,0,0, 1,0,4,1,0,1));
        vecs.push_back(mk(1,1,0,0, 1,0,4,1,0,0));
        vecs.push_back(mk(1,1,0,0, 1,0,4,1,0,0));
        vecs.push_back(mk(1,1,1,5, 1,0,5,1,1,1));   // 5 on boundary -> HHHLL
        vecs.push_back(mk(1,1,0,0, 1,0,5,1,0,1));
        vecs.push_back(mk(1,1,0,0, 1,0,5,1,0,1));
        vecs.push_back(mk(1,1,0,0, 1,0,5,1,0,0));
        vecs.push_back(mk(1,1,0,0, 1,0,5,1,0,0));
        vecs.push_back(mk(1,1,0,0, 1,0,5,1,1,1));
        vecs.push_back(mk(1,1,0,0, 1,0,5,1,0,1));
        vecs.push_back(mk(1,1,0,0, 1,0,5,1,0,1));
        vecs.push_back(mk(1,1,0,0, 1,0,5,1,0,0));
        vecs.push_back(mk(1,1,0,0, 1,0,5,1,0,0));
        vecs.push_back(mk(1,1,1,4, 1,0,4,1,1,1));   // back to 4 on boundary
        vecs.push_back(mk(1,1,0,0, 1,0,4,1,0,1));
        vecs.push_back(mk(1,0,0,0, 1,0,4,1,0,0));   // drop at cnt1 -> STOP
        vecs.push_back(mk(1,0,0,0, 1,0,4,1,0,0));
        vecs.push_back(mk(1,0,0,0, 1,0,4,0,0,0));   // OFF
        vecs.push_back(mk(1,0,0,0, 1,0,4,0,0,0));
        vecs.push_back(mk(1,1,0,0, 1,0,4,1,1,1));   // restart
        vecs.push_back(mk(1,1,1,6, 0,0,4,1,0,1));   // PEND with 6
        vecs.push_back(mk(0,1,0,0, 1,0,3,0,0,0));   // reset during PEND
        vecs.push_back(mk(1,1,0,0, 1,0,3,1,1,1));
        vecs.push_back(mk(1,1,0,0, 1,0,3,1,0,1));
        vecs.push_back(mk(1,1,0,0, 1,0,3,1,0,0));
        vecs.push_back(mk(1,0,0,0, 1,0,3,0,0,0));   // drop on boundary -> OFF
        vecs.push_back(mk(1,1,0,0, 1,0,3,1,1,1));
        vecs.push_back(mk(1,0,1,2, 1,0,3,1,0,1));   // accept + drop -> STOP pending
        vecs.push_back(mk(1,0,0,0, 1,0,3,1,0,0));
        vecs.push_back(mk(1,0,0,0, 1,0,2,0,0,0));   // pending applied on OFF
        vecs.push_back(mk(1,1,0,0, 1,0,2,1,1,1));
        vecs.push_back(mk(1,1,0,0, 1,0,2,1,0,0));
        vecs.push_back(mk(1,1,0,0, 1,0,2,1,1,1));
        vecs.push_back(mk(1,0,0,0, 1,0,2,1,0,0));
        vecs.push_back(mk(1,0,0,0, 1,0,2,0,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n = vecs[i].rst_n;
            div_en = vecs[i].en;
            cfg_valid = vecs[i].v;
            cfg_div = vecs[i].d;
            sb.push_back(vecs[i]);
            step();
            e = sb.pop_front();
            chk($sformatf("v%0d.ready", i), 32'(cfg_ready), 32'(e.ready));
            chk($sformatf("v%0d.err", i), 32'(cfg_err), 32'(e.err));
            chk($sformatf("v%0d.cur", i), 32'(cur_div), 32'(e.cur));
            chk($sformatf("v%0d.busy", i), 32'(div_busy), 32'(e.busy));
            chk($sformatf("v%0d.tick", i), 32'(period_tick), 32'(e.tick));
            chk($sformatf("v%0d.clk", i), 32'(div_clk), 32'(e.dclk));
        end

        // ratio 7 loaded while OFF, then one full two-period window
        cfg_valid = 1'b1; cfg_div = 8'd7; div_en = 1'b0;
        step();
        cfg_valid = 1'b0;
        chk("off_load.cur", 32'(cur_div), 32'd7);
        chk("off_load.busy", 32'(div_busy), 32'd0);
        div_en = 1'b1;
        step();
        for (int k = 0; k < 20 && !period_tick; k++) step();
        chk("n7.tick_wait", 32'(period_tick), 32'd1);
        ticks = 0; highs = 0;
        for (int k = 0; k < 14; k++) begin
            ticks += int'(period_tick);
            highs += int'(div_clk);
            step();
        end
        chk("n7.ticks", 32'(ticks), 32'd2);
        chk("n7.highs", 32'(highs), 32'd8);

        // ratio 0 is illegal: one-cycle error, ratio kept
        cfg_valid = 1'b1; cfg_div = 8'd0;
        step();
        cfg_valid = 1'b0;
        chk("zero.err", 32'(cfg_err), 32'd1);
        chk("zero.cur", 32'(cur_div), 32'd7);
        step();
        chk("zero.err_clear", 32'(cfg_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
